// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 2-bit branch counter encodings, default PC width,
// and the saturating counter update used by the branch predictor.
package cpu_pkg;

  localparam int BP_PC_W = 32;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CNT_ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_entry_table.sv
// Predictor storage: valid/tag/target/counter per entry, async clear to
// "empty, weakly not-taken". One lookup read port and one write port whose
// current contents are exposed so the caller can do read-modify-write.
module bp_entry_table
  import cpu_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int PC_W  = BP_PC_W
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [PC_W-1:0]  rd_target,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic [1:0]       wr_cnt,
  output logic             cur_valid,
  output logic [TAG_W-1:0] cur_tag,
  output logic [PC_W-1:0]  cur_target,
  output logic [1:0]       cur_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [DEPTH-1:0][PC_W-1:0]  target_q;
  logic [DEPTH-1:0][1:0]       cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WNT;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      cnt_q[wr_idx]    <= wr_cnt;
    end
  end

  assign rd_valid   = valid_q[rd_idx];
  assign rd_tag     = tag_q[rd_idx];
  assign rd_target  = target_q[rd_idx];
  assign rd_cnt     = cnt_q[rd_idx];

  assign cur_valid  = valid_q[wr_idx];
  assign cur_tag    = tag_q[wr_idx];
  assign cur_target = target_q[wr_idx];
  assign cur_cnt    = cnt_q[wr_idx];

endmodule

// File: rtl/branch_predictor.sv
// IF-stage tagged bimodal branch predictor with EX-stage training and
// mispredict flagging. Define BP_STATS_EN to build the branch/mispredict counters.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int PC_W  = BP_PC_W
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [PC_W-1:0] upd_pred_target_i,
  output logic            mispredict_o,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;

  assign lk_idx  = pc_i[IDX_W+1:2];
  assign lk_tag  = pc_i[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[TAG_HI:TAG_LO];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[1:0], pc_i[PC_W-1:TAG_HI+1],
                            upd_pc_i[1:0], upd_pc_i[PC_W-1:TAG_HI+1]};

  // Blocks training on the first edge after reset release, so an update
  // presented while reset is being deasserted never lands in the table.
  logic rst_seen_q;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) rst_seen_q <= 1'b0;
    else        rst_seen_q <= 1'b1;
  end

  logic upd_en;
  assign upd_en = upd_valid_i & rst_seen_q;

  logic             rd_valid, cur_valid, wr_en, wr_valid;
  logic [TAG_W-1:0] rd_tag, cur_tag, wr_tag;
  logic [PC_W-1:0]  rd_target, cur_target, wr_target;
  logic [1:0]       rd_cnt, cur_cnt, wr_cnt;

  bp_entry_table #(.IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) u_table (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_idx     (lk_idx),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_cnt     (rd_cnt),
    .wr_en      (wr_en),
    .wr_idx     (upd_idx),
    .wr_valid   (wr_valid),
    .wr_tag     (wr_tag),
    .wr_target  (wr_target),
    .wr_cnt     (wr_cnt),
    .cur_valid  (cur_valid),
    .cur_tag    (cur_tag),
    .cur_target (cur_target),
    .cur_cnt    (cur_cnt)
  );

  // Lookup sees registered state only; a same-cycle update is not bypassed.
  logic lk_hit;
  assign lk_hit        = rd_valid & (rd_tag == lk_tag);
  assign pred_taken_o  = lk_hit & rd_cnt[1];
  assign pred_target_o = pred_taken_o ? rd_target : '0;

  logic upd_hit;
  assign upd_hit = cur_valid & (cur_tag == upd_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = cur_valid;
    wr_tag    = cur_tag;
    wr_target = cur_target;
    wr_cnt    = cur_cnt;
    if (upd_en) begin
      if (upd_hit) begin
        wr_en  = 1'b1;
        wr_cnt = sat_cnt_next(cur_cnt, upd_taken_i);
        if (upd_taken_i) wr_target = upd_target_i;
      end else if (upd_taken_i) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = upd_tag;
        wr_target = upd_target_i;
        wr_cnt    = CNT_WT;
      end
    end
  end

  // Held low while in reset so the hazard unit never flushes on stale EX data.
  assign mispredict_o = rst_n & upd_valid_i &
                        ((upd_pred_taken_i ^ upd_taken_i) |
                         (upd_taken_i & (upd_pred_target_i != upd_target_i)));

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (upd_en) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_o && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end
  assign stat_branches_o = br_cnt_q;
  assign stat_mispred_o  = mp_cnt_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed steps push hand-computed
// expectations; a negedge monitor pops and compares the combinational outputs.
module tb_branch_predictor;

  localparam int IDX_W = 4;
  localparam int TAG_W = 8;
  localparam int PC_W  = 32;

  logic            clk_i = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] pc_i;
  logic            pred_taken_o;
  logic [PC_W-1:0] pred_target_o;
  logic            upd_valid_i;
  logic [PC_W-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [PC_W-1:0] upd_target_i;
  logic            upd_pred_taken_i;
  logic [PC_W-1:0] upd_pred_target_i;
  logic            mispredict_o;
  logic [31:0]     stat_branches_o;
  logic [31:0]     stat_mispred_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) dut (
    .clk_i             (clk_i),
    .rst_n             (rst_n),
    .pc_i              (pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .mispredict_o      (mispredict_o),
    .stat_branches_o   (stat_branches_o),
    .stat_mispred_o    (stat_mispred_o)
  );

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int exp_br = 0;
  int exp_mp = 0;
  logic prev_rst = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "pred_taken",  {31'd0, pred_taken_o}, {31'd0, e.pt});
      chk(e.name, "pred_target", pred_target_o, e.tgt);
      chk(e.name, "mispredict",  {31'd0, mispredict_o}, {31'd0, e.mp});
      chk(e.name, "stat_br",     stat_branches_o, e.sb);
      chk(e.name, "stat_mp",     stat_mispred_o, e.sm);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected before the next edge.
  task automatic step(input logic rst, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                      input logic e_pt, input logic [31:0] e_tgt, input logic e_mp,
                      input string nm);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_n = rst; pc_i = pc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    upd_pred_taken_i = upt; upd_pred_target_i = uptgt;
    if (!rst) begin exp_br = 0; exp_mp = 0; end
    e.name = nm; e.pt = e_pt; e.tgt = e_tgt; e.mp = e_mp;
`ifdef BP_STATS_EN
    e.sb = exp_br; e.sm = exp_mp;
`else
    e.sb = 32'd0; e.sm = 32'd0;
`endif
    q.push_back(e);
    if (rst && prev_rst && uv) begin
      exp_br++;
      if (e_mp) exp_mp++;
    end
    prev_rst = rst;
  endtask

  initial begin
    rst_n = 1'b0; pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    upd_target_i = '0; upd_pred_taken_i = 1'b0; upd_pred_target_i = '0;
    repeat (2) @(posedge clk_i);
    //   rst pc     uv upc    ut tgt     upt ptgt     e_pt e_tgt  e_mp
    step(0, 'h40,  1, 'h40,  1, 'h80,   0, 'h0,      0, 'h0,    0, "in_reset");
    step(1, 'h40,  1, 'h40,  1, 'h80,   0, 'h0,      0, 'h0,    1, "rst_release_upd");
    step(1, 'h40,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "ignored_upd");
    step(1, 'h40,  1, 'h40,  1, 'h80,   0, 'h0,      0, 'h0,    1, "alloc");
    step(1, 'h40,  1, 'h40,  1, 'h80,   1, 'h80,     1, 'h80,   0, "cnt10_t");
    step(1, 'h40,  1, 'h40,  1, 'h80,   1, 'h80,     1, 'h80,   0, "cnt11_t");
    step(1, 'h40,  1, 'h40,  0, 'h0,    1, 'h80,     1, 'h80,   1, "cnt11_nt");
    step(1, 'h40,  1, 'h40,  0, 'h0,    1, 'h80,     1, 'h80,   1, "cnt10_nt");
    step(1, 'h40,  1, 'h40,  0, 'h0,    0, 'h0,      0, 'h0,    0, "cnt01_nt");
    step(1, 'h40,  1, 'h40,  0, 'h0,    0, 'h0,      0, 'h0,    0, "cnt00_nt");
    step(1, 'h40,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "cnt00_hold");
    step(1, 'h40,  1, 'h40,  1, 'h80,   0, 'h0,      0, 'h0,    1, "cnt00_t");
    step(1, 'h40,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "cnt01_no_realloc");
    step(1, 'h40,  1, 'h80,  1, 'h200,  0, 'h0,      0, 'h0,    1, "alias_alloc");
    step(1, 'h40,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "alias_evict");
    step(1, 'h80,  1, 'h80,  1, 'h300,  1, 'h200,    1, 'h200,  1, "tgt_mismatch");
    step(1, 'h80,  0, 'h0,   0, 'h0,    0, 'h0,      1, 'h300,  0, "tgt_updated");
    step(1, 'h44,  1, 'h44,  1, 'h120,  0, 'h0,      0, 'h0,    1, "same_cycle");
    step(1, 'h44,  1, 'h44,  1, 'h120,  1, 'h120,    1, 'h120,  0, "correct_pred");
    step(1, 'h48,  1, 'h48,  0, 'h0,    0, 'h0,      0, 'h0,    0, "nt_miss");
    step(1, 'h48,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "nt_no_alloc");
    step(1, 'h47,  0, 'h44,  1, 'h999,  0, 'h0,      1, 'h120,  0, "low_bits_uv0");
    step(1, 'h44,  0, 'h0,   0, 'h0,    0, 'h0,      1, 'h120,  0, "uv0_unchanged");
    step(0, 'h80,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "midrun_reset");
    step(1, 'h80,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "post_reset_80");
    step(1, 'h44,  0, 'h0,   0, 'h0,    0, 'h0,      0, 'h0,    0, "post_reset_44");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
    @(posedge clk_i);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
